// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, ack check); watchdog built only with PS2_TX_TIMEOUT_EN.
// Latency: clock inhibited the cycle after accept for INHIBIT_CYCLES cycles; data line follows a pin falling edge by 3 clk_i cycles.
// Backpressure: tx_ready_o only in IDLE; tx_valid_i while busy is ignored and must be held by the requester.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       tx_done_o,
    output logic       tx_error_o,
    output logic       busy_o
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ps2_transmitter: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_n;
    logic [IW-1:0] inh_cnt_q, inh_cnt_n;
    logic [3:0]    bit_idx_q, bit_idx_n;
    logic [8:0]    frame_q, frame_n;
    logic          ok_q, ok_n;
    logic          clk_oe_q, clk_oe_n;
    logic          data_oe_q, data_oe_n;
    logic          done_q, done_n;
    logic          error_q, error_n;

    logic clk_meta, clk_s, clk_s_d;
    logic data_meta, data_s;
    logic ps2_fall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_meta  <= 1'b1;
            clk_s     <= 1'b1;
            clk_s_d   <= 1'b1;
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_s     <= clk_meta;
            clk_s_d   <= clk_s;
            data_meta <= ps2_data_i;
            data_s    <= data_meta;
        end
    end

    assign ps2_fall = clk_s_d & ~clk_s;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_n;
    logic          wd_active;

    assign wd_active = (state_q == S_RTS) || (state_q == S_DATA) ||
                       (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_n;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            ok_q      <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            inh_cnt_q <= inh_cnt_n;
            bit_idx_q <= bit_idx_n;
            frame_q   <= frame_n;
            ok_q      <= ok_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            done_q    <= done_n;
            error_q   <= error_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        inh_cnt_n = inh_cnt_q;
        bit_idx_n = bit_idx_q;
        frame_n   = frame_q;
        ok_n      = ok_q;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        done_n    = 1'b0;
        error_n   = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wd_n      = wd_active ? wd_q + WW'(1) : wd_q;
`endif

        case (state_q)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid_i) begin
                    frame_n   = {~^tx_data_i, tx_data_i};
                    inh_cnt_n = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    bit_idx_n = '0;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_n      = '0;
`endif
                    state_n   = S_RTS;
                end else begin
                    inh_cnt_n = inh_cnt_q + IW'(1);
                end
            end
            S_RTS, S_DATA: begin
                // Edges 1..9 present data LSB first then parity; edge 10 releases for the stop bit.
                if (ps2_fall) begin
                    if (bit_idx_q < 4'd9) begin
                        data_oe_n = ~frame_q[bit_idx_q];
                        bit_idx_n = bit_idx_q + 4'd1;
                        state_n   = S_DATA;
                    end else begin
                        data_oe_n = 1'b0;
                        state_n   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (ps2_fall) begin
                    ok_n    = ~data_s;
                    state_n = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_n  = ok_q;
                    error_n = ~ok_q;
                    state_n = S_IDLE;
                end
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog overrides any completion seen in the same cycle.
        if (wd_active && (wd_q == WW'(TIMEOUT_CYCLES - 1))) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            done_n    = 1'b0;
            error_n   = 1'b1;
            state_n   = S_IDLE;
        end
`endif
    end

    assign tx_ready_o    = (state_q == S_IDLE);
    assign busy_o        = ~tx_ready_o;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign tx_done_o     = done_q;
    assign tx_error_o    = error_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain line model, PS/2 device model, table of frames scored through a queue.
module tb_ps2_transmitter;

    localparam int INH  = 50;
    localparam int TMO  = 1000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, clk_oe, data_oe, tx_done, tx_error, busy;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(clk_oe | dev_clk_low);
    assign ps2_data = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .ps2_clk_oe_o(clk_oe), .ps2_data_oe_o(data_oe), .tx_done_o(tx_done),
        .tx_error_o(tx_error), .busy_o(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
    int bad_ready = 0, bad_excl = 0, bad_busy = 0;
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_valid && tx_ready && !rst) acc_cnt++;
        if ((tx_done || tx_error) && !tx_ready) bad_ready++;
        if (tx_done && tx_error) bad_excl++;
        if (busy !== ~tx_ready) bad_busy++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drives a request and waits for acceptance; optionally keeps tx_valid_i asserted with a new byte.
    task automatic send(input logic [7:0] d, input bit hold, input logic [7:0] next_d);
        int k = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        if (hold) tx_data = next_d;
        else tx_valid = 1'b0;
        chk("ready_after_accept", {31'd0, tx_ready}, 32'd0);
        chk("clk_oe_after_accept", {31'd0, clk_oe}, 32'd1);
    endtask

    task automatic inhibit_check();
        int n = 0;
        while (clk_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
        chk("rts_clk_release", {31'd0, clk_oe}, 32'd0);
        chk("start_bit", {31'd0, data_oe}, 32'd1);
    endtask

    task automatic dev_frame(input bit ack);
        logic [9:0] got = '0;
        logic [9:0] exp;
        for (int i = 1; i <= 11; i++) begin
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            if (i <= 10) got[i-1] = ps2_data;
            if (i == 10) dev_data_low = ack;
        end
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            chk("frame_bits", {22'd0, got}, {22'd0, exp});
        end
    endtask

    task automatic dev_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         ack;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, e0, a0, k;
        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        vecs[5] = '{8'h07, 1'b0, 1'b0, 0, 1};

        repeat (3) @(negedge clk);
        chk("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_error", {31'd0, tx_error}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            d0 = done_cnt;
            e0 = err_cnt;
            exp_q.push_back({1'b1, vecs[i].par, vecs[i].data});
            send(vecs[i].data, 1'b0, 8'h00);
            inhibit_check();
            dev_frame(vecs[i].ack);
            repeat (20) @(negedge clk);
            chk("done_pulses", done_cnt - d0, vecs[i].exp_done);
            chk("error_pulses", err_cnt - e0, vecs[i].exp_err);
            chk("idle_ready", {31'd0, tx_ready}, 32'd1);
        end

        // Back-pressure: 0x55 held during the 0xAA transfer, taken when ready returns.
        d0 = done_cnt;
        a0 = acc_cnt;
        exp_q.push_back({1'b1, 1'b1, 8'hAA});
        exp_q.push_back({1'b1, 1'b1, 8'h55});
        send(8'hAA, 1'b1, 8'h55);
        inhibit_check();
        dev_frame(1'b1);
        k = 0;
        while (!tx_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("bp_done_seen", {31'd0, tx_done}, 32'd1);
        chk("bp_ready_at_done", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("bp_second_accept", {31'd0, clk_oe}, 32'd1);
        chk("bp_accept_count", acc_cnt - a0, 2);
        inhibit_check();
        dev_frame(1'b1);
        repeat (20) @(negedge clk);
        chk("bp_done_pulses", done_cnt - d0, 2);

        // Reset after the 4th device clock edge: lines drop asynchronously, no pulses.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h35, 1'b0, 8'h00);
        inhibit_check();
        dev_pulses(4);
        chk("edge4_bit3_low", {31'd0, data_oe}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("arst_data_oe", {31'd0, data_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_ready", {31'd0, tx_ready}, 32'd1);
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_no_error", err_cnt - e0, 0);

        // Recovery transfer after reset.
        d0 = done_cnt;
        exp_q.push_back({1'b1, 1'b0, 8'h80});
        send(8'h80, 1'b0, 8'h00);
        inhibit_check();
        dev_frame(1'b1);
        repeat (20) @(negedge clk);
        chk("recover_done", done_cnt - d0, 1);

`ifdef PS2_TX_TIMEOUT_EN
        e0 = err_cnt;
        send(8'hF4, 1'b0, 8'h00);
        inhibit_check();
        k = 0;
        while (!tx_error && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", k, TMO);
        chk("timeout_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("timeout_data_oe", {31'd0, data_oe}, 32'd0);
        chk("timeout_ready", {31'd0, tx_ready}, 32'd1);
        repeat (5) @(negedge clk);
        chk("timeout_err_pulses", err_cnt - e0, 1);
`endif

        chk("ready_during_pulse", bad_ready, 0);
        chk("pulse_exclusive", bad_excl, 0);
        chk("busy_is_not_ready", bad_busy, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
